// File: rtl/bean_spawn_scheduler_if.sv
// rtl/bean_spawn_scheduler_if.sv - spawn request handshake between scheduler and bean datapath
//
// Signals:
//   spawn_valid  scheduler -> datapath  spawn request pending
//   spawn_slot   scheduler -> datapath  target bean slot index
//   spawn_pos    scheduler -> datapath  spawn x position
//   spawn_type   scheduler -> datapath  0 floor bean, 1 flying bean
//   spawn_ack    datapath -> scheduler  current spawn accepted
// Modports: master (scheduler side), slave (datapath side).

interface bean_spawn_scheduler_if;
  logic       spawn_valid;
  logic [1:0] spawn_slot;
  logic [9:0] spawn_pos;
  logic       spawn_type;
  logic       spawn_ack;

  modport master (
    output spawn_valid,
    output spawn_slot,
    output spawn_pos,
    output spawn_type,
    input  spawn_ack
  );

  modport slave (
    input  spawn_valid,
    input  spawn_slot,
    input  spawn_pos,
    input  spawn_type,
    output spawn_ack
  );
endinterface

// File: rtl/bean_spawn_scheduler.sv
// rtl/bean_spawn_scheduler.sv - decides when and where the next bean spawns on a scrolling screen
//
// Optional feature macro: BEAN_SPAWN_FLYING_EN (spawn_type taken from LFSR bit 0;
// when undefined every spawn is a floor bean).
//
// Ports:
//   clk_rand   in   sole clock
//   reset      in   synchronous, active-high
//   tick       in   one-cycle scroll strobe
//   stop       in   collision/halt request
//   score      in   current score (32-bit unsigned)
//   slot_free  in   bit i high: bean slot i is reusable
//   halted     out  high while halted
//   spawn      if   master side of the spawn handshake (valid/slot/pos/type, ack)

module bean_spawn_scheduler #(
  parameter int SCREEN_W      = 640,
  parameter int SHIFT         = 5,
  parameter int GAP_START     = 400,
  parameter int GAP_FLOOR     = 150,
  parameter int RANGE_START   = 150,
  parameter int RANGE_FLOOR   = 25,
  parameter int FURTHEST_INIT = 750
) (
  input  logic                          clk_rand,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          stop,
  input  logic [31:0]                   score,
  input  logic [3:0]                    slot_free,
  output logic                          halted,
  bean_spawn_scheduler_if.master        spawn
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam logic [10:0] SHIFT_11      = 11'(SHIFT);
  localparam logic [9:0]  SHIFT_10      = 10'(SHIFT);
  localparam logic [11:0] SCREEN_W_12   = 12'(SCREEN_W);
  localparam logic [9:0]  SCREEN_W_10   = 10'(SCREEN_W);
  localparam logic [31:0] GAP_START_32  = 32'(GAP_START);
  localparam logic [31:0] GAP_KNEE      = 32'(GAP_START - GAP_FLOOR);
  localparam logic [10:0] GAP_FLOOR_11  = 11'(GAP_FLOOR);
  localparam logic [10:0] GAP_START_11  = 11'(GAP_START);
  localparam logic [9:0]  RANGE_FLOOR_10 = 10'(RANGE_FLOOR);
  localparam logic [9:0]  RANGE_START_10 = 10'(RANGE_START);
  localparam logic [10:0] FURTHEST_11   = 11'(FURTHEST_INIT);
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  // Right-shifting Galois form of taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  state_t      state_q, state_d;
  logic [10:0] furthest_q, furthest_d;
  logic [10:0] min_gap_q, min_gap_d;
  logic [9:0]  range_q, range_d;
  logic [9:0]  offset_q, offset_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        parity_q, parity_d;
  logic        valid_q, valid_d;
  logic [1:0]  slot_q, slot_d;
  logic [9:0]  pos_q, pos_d;
  logic        type_q, type_d;

  logic        eligible;
  logic [1:0]  slot_new;
  logic        type_new;
  logic [9:0]  offset_sum;
  logic [10:0] furthest_ticked;

  // Lowest free slot wins.
  always_comb begin
    slot_new = 2'd0;
    if (slot_free[0])      slot_new = 2'd0;
    else if (slot_free[1]) slot_new = 2'd1;
    else if (slot_free[2]) slot_new = 2'd2;
    else if (slot_free[3]) slot_new = 2'd3;
  end

`ifdef BEAN_SPAWN_FLYING_EN
  assign type_new = lfsr_q[0];
`else
  assign type_new = 1'b0;
`endif

  // furthest <= SCREEN_W - min_gap, rearranged so it never goes negative.
  assign eligible = (({1'b0, furthest_q} + {1'b0, min_gap_q}) <= SCREEN_W_12) && (slot_free != 4'd0);

  assign offset_sum      = offset_q + SHIFT_10;
  assign furthest_ticked = (furthest_q >= SHIFT_11) ? (furthest_q - SHIFT_11) : 11'd0;

  always_comb begin
    state_d    = state_q;
    furthest_d = furthest_q;
    range_d    = range_q;
    offset_d   = offset_q;
    parity_d   = parity_q;
    valid_d    = valid_q;
    slot_d     = slot_q;
    pos_d      = pos_q;
    type_d     = type_q;
    lfsr_d     = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & LFSR_TAPS);
    min_gap_d  = (score >= GAP_KNEE) ? GAP_FLOOR_11 : 11'(GAP_START_32 - score);

    // Scroll-driven state advances only while live and not being stopped.
    if ((state_q != ST_HALT) && !stop) begin
      offset_d = (offset_sum > range_q) ? 10'd0 : offset_sum;
      if (tick) begin
        furthest_d = furthest_ticked;
        parity_d   = ~parity_q;
        if (parity_q && (range_q > RANGE_FLOOR_10))
          range_d = range_q - 10'd1;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (stop) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else if (eligible) begin
          state_d = ST_WAIT_ACK;
          valid_d = 1'b1;
          slot_d  = slot_new;
          pos_d   = SCREEN_W_10 + offset_q;
          type_d  = type_new;
        end
      end
      ST_WAIT_ACK: begin
        // Ack is committed even when stop arrives on the same edge, and it
        // overrides any tick decrement.
        if (spawn.spawn_ack) begin
          furthest_d = {1'b0, pos_q};
          valid_d    = 1'b0;
          state_d    = stop ? ST_HALT : ST_RUN;
        end else if (stop) begin
          valid_d = 1'b0;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_rand) begin
    if (reset) begin
      state_q    <= ST_RUN;
      furthest_q <= FURTHEST_11;
      min_gap_q  <= GAP_START_11;
      range_q    <= RANGE_START_10;
      offset_q   <= 10'd0;
      lfsr_q     <= LFSR_SEED;
      parity_q   <= 1'b0;
      valid_q    <= 1'b0;
      slot_q     <= 2'd0;
      pos_q      <= 10'd0;
      type_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      furthest_q <= furthest_d;
      min_gap_q  <= min_gap_d;
      range_q    <= range_d;
      offset_q   <= offset_d;
      lfsr_q     <= lfsr_d;
      parity_q   <= parity_d;
      valid_q    <= valid_d;
      slot_q     <= slot_d;
      pos_q      <= pos_d;
      type_q     <= type_d;
    end
  end

  assign halted            = (state_q == ST_HALT);
  assign spawn.spawn_valid = valid_q;
  assign spawn.spawn_slot  = slot_q;
  assign spawn.spawn_pos   = pos_q;
  assign spawn.spawn_type  = type_q;

endmodule
